// File: rtl/core_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter: state encoding,
// default widths, wait-state bound and the slot-counter width helper.
package core_mem_pkg;

  localparam int ADDR_W_DEF   = 15;
  localparam int DATA_W_DEF   = 16;
  localparam int WAIT_CYC_MAX = 15;

  typedef enum logic [2:0] {
    IREAD  = 3'd0,
    DWRITE = 3'd1,
    DSWPR  = 3'd2,
    DSWPW  = 3'd3,
    DREAD  = 3'd4
  } memState_t;

  // Counter must hold 0..waitCyc; never narrower than one bit.
  function automatic int cntWidth(input int waitCyc);
    if (waitCyc < 1) begin
      return 1;
    end else begin
      return $clog2(waitCyc + 1);
    end
  endfunction

endpackage

// File: rtl/core_mem_slot_timer.sv
// Slot counter: counts 0..WAIT_CYC and flags the last cycle of each memory slot.
module core_mem_slot_timer
  import core_mem_pkg::*;
#(
  parameter int WAIT_CYC = 0
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  output logic o_slotEnd
);

  localparam int CW = cntWidth(WAIT_CYC);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYC);

  logic [CW-1:0] cnt_r;

  assign o_slotEnd = (cnt_r == LAST);

  // Slot cycle counter, wrapping at slot end or on an explicit clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_r <= '0;
    end else if (i_clr || o_slotEnd) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Interleaves instruction fetches with data read/write/swap accesses on one
// shared tristate memory bus. Optional fetch pause: define CORE_MEM_IPAUSE_EN.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_CYC = 0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [ADDR_W-1:0] i_iAddr,
  output logic              o_iBusy,
  output logic [DATA_W-1:0] o_iData,
  output logic              o_iValid,
  input  logic [ADDR_W-1:0] i_dAddr,
  input  logic [DATA_W-1:0] i_dData,
  input  logic              i_dWr,
  input  logic              i_dSwp,
  input  logic              i_dEn,
  output logic [DATA_W-1:0] o_dData,
  output logic              o_dIsReading,
  output logic              o_dIsDone,
  output logic [ADDR_W:0]   o_memAddr,
  inout  logic [DATA_W-1:0] io_memData,
  output logic              o_memWr
`ifdef CORE_MEM_IPAUSE_EN
  ,
  input  logic              i_iPause
`endif
);

  memState_t         state_r;
  memState_t         stateNext_s;
  logic              slotEnd_s;
  logic              stateChange_s;
  logic              pause_s;
  logic              memWr_s;
  logic [ADDR_W-1:0] aBuf_r;
  logic [DATA_W-1:0] dBuf_r;
  logic [DATA_W-1:0] iData_r;
  logic [DATA_W-1:0] dData_r;
  logic              iValid_r;
  logic              dDone_r;

`ifdef CORE_MEM_IPAUSE_EN
  assign pause_s = i_iPause;
`else
  assign pause_s = 1'b0;
`endif

  core_mem_slot_timer #(
    .WAIT_CYC (WAIT_CYC)
  ) uSlotTimer (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_clr     (stateChange_s),
    .o_slotEnd (slotEnd_s)
  );

  // Next-state selection; transitions happen only on the last cycle of a slot.
  always_comb begin
    stateNext_s = state_r;
    if (slotEnd_s) begin
      case (state_r)
        IREAD: begin
          if (i_dEn) begin
            if (i_dSwp) begin
              stateNext_s = DSWPR;
            end else if (i_dWr) begin
              stateNext_s = DWRITE;
            end else begin
              stateNext_s = DREAD;
            end
          end else begin
            stateNext_s = IREAD;
          end
        end
        DSWPR:   stateNext_s = DSWPW;
        DREAD:   stateNext_s = IREAD;
        DWRITE:  stateNext_s = IREAD;
        DSWPW:   stateNext_s = IREAD;
        default: stateNext_s = IREAD;
      endcase
    end else begin
      stateNext_s = state_r;
    end
  end

  assign stateChange_s = (stateNext_s != state_r);

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= IREAD;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Latch the data request at the fetch slot end so the requester may change it later.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      aBuf_r <= '0;
      dBuf_r <= '0;
    end else if (slotEnd_s && (state_r == IREAD) && i_dEn) begin
      aBuf_r <= i_dAddr;
      dBuf_r <= i_dData;
    end
  end

  // Read-data capture and one-cycle valid/done pulses.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      iData_r  <= '0;
      dData_r  <= '0;
      iValid_r <= 1'b0;
      dDone_r  <= 1'b0;
    end else begin
      iValid_r <= 1'b0;
      dDone_r  <= 1'b0;
      if (slotEnd_s) begin
        case (state_r)
          IREAD: begin
            if (!pause_s) begin
              iData_r  <= io_memData;
              iValid_r <= 1'b1;
            end
          end
          DSWPR: dData_r <= io_memData;
          DREAD: begin
            dData_r <= io_memData;
            dDone_r <= 1'b1;
          end
          DWRITE:  dDone_r <= 1'b1;
          DSWPW:   dDone_r <= 1'b1;
          default: dDone_r <= 1'b0;
        endcase
      end
    end
  end

  assign memWr_s      = (state_r == DWRITE) || (state_r == DSWPW);
  assign o_memWr      = memWr_s;
  assign io_memData   = memWr_s ? dBuf_r : {DATA_W{1'bz}};
  assign o_memAddr    = (state_r == IREAD) ? {1'b0, i_iAddr} : {1'b1, aBuf_r};
  assign o_iBusy      = (state_r != IREAD);
  assign o_dIsReading = (state_r == DREAD) || (state_r == DSWPR);
  assign o_iData      = iData_r;
  assign o_iValid     = iValid_r;
  assign o_dData      = dData_r;
  assign o_dIsDone    = dDone_r;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: one instance with no wait states, one with three.
module tb_core_mem_arbiter;

  logic        clk;
  logic        rstn0, rstn3;
  logic [14:0] iAddr, dAddr;
  logic [15:0] dData;
  logic        dWr, dSwp, dEn0, dEn3, iPause;

  logic        busy0, iValid0, dRd0, done0, memWr0;
  logic [15:0] iData0, dOut0, memAddr0;
  wire  [15:0] bus0;
  logic        busy3, iValid3, dRd3, done3, memWr3;
  logic [15:0] iData3, dOut3, memAddr3;
  wire  [15:0] bus3;

  logic [15:0] wrAddr0, wrData0;
  int nTests = 0;
  int nFail  = 0;
  int cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memRead(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hA5A5;
      16'h8123: return 16'h1234;
      16'h8050: return 16'h1111;
      16'h8200: return 16'hC3C3;
      default:  return 16'h0000;
    endcase
  endfunction

  assign bus0 = memWr0 ? 16'hzzzz : memRead(memAddr0);
  assign bus3 = memWr3 ? 16'hzzzz : memRead(memAddr3);

  always @(posedge clk) begin
    if (memWr0) begin
      wrAddr0 <= memAddr0;
      wrData0 <= bus0;
    end
  end

  core_mem_arbiter #(.ADDR_W(15), .DATA_W(16), .WAIT_CYC(0)) dut0 (
    .i_clk(clk), .i_rstn(rstn0), .i_iAddr(iAddr), .o_iBusy(busy0),
    .o_iData(iData0), .o_iValid(iValid0), .i_dAddr(dAddr), .i_dData(dData),
    .i_dWr(dWr), .i_dSwp(dSwp), .i_dEn(dEn0), .o_dData(dOut0),
    .o_dIsReading(dRd0), .o_dIsDone(done0), .o_memAddr(memAddr0),
    .io_memData(bus0), .o_memWr(memWr0)
`ifdef CORE_MEM_IPAUSE_EN
    , .i_iPause(iPause)
`endif
  );

  core_mem_arbiter #(.ADDR_W(15), .DATA_W(16), .WAIT_CYC(3)) dut3 (
    .i_clk(clk), .i_rstn(rstn3), .i_iAddr(iAddr), .o_iBusy(busy3),
    .o_iData(iData3), .o_iValid(iValid3), .i_dAddr(dAddr), .i_dData(dData),
    .i_dWr(dWr), .i_dSwp(dSwp), .i_dEn(dEn3), .o_dData(dOut3),
    .o_dIsReading(dRd3), .o_dIsDone(done3), .o_memAddr(memAddr3),
    .io_memData(bus3), .o_memWr(memWr3)
`ifdef CORE_MEM_IPAUSE_EN
    , .i_iPause(1'b0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn0 = 1'b0; rstn3 = 1'b0;
    iAddr = 15'h0010; dAddr = 15'h0000; dData = 16'h0000;
    dWr = 1'b0; dSwp = 1'b0; dEn0 = 1'b0; dEn3 = 1'b0; iPause = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_iValid", {31'd0, iValid0}, 32'd0);
    check("rst_iData", {16'd0, iData0}, 32'd0);
    check("rst_dData", {16'd0, dOut0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_memWr", {31'd0, memWr0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_bus", {16'd0, bus0}, 32'h0000A5A5);

    rstn0 = 1'b1; rstn3 = 1'b1;

    // Idle fetch, no wait states
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fetch_addr", {16'd0, memAddr0}, 32'h0010);
      check("fetch_valid", {31'd0, iValid0}, 32'd1);
      check("fetch_data", {16'd0, iData0}, 32'hA5A5);
    end

    // Data read
    dAddr = 15'h0123; dWr = 1'b0; dSwp = 1'b0; dEn0 = 1'b1;
    tick();
    check("rd_addr", {16'd0, memAddr0}, 32'h8123);
    check("rd_isReading", {31'd0, dRd0}, 32'd1);
    check("rd_busy", {31'd0, busy0}, 32'd1);
    check("rd_noDoneYet", {31'd0, done0}, 32'd0);
    tick();
    check("rd_data", {16'd0, dOut0}, 32'h1234);
    check("rd_done", {31'd0, done0}, 32'd1);
    check("rd_noFetchValid", {31'd0, iValid0}, 32'd0);
    check("rd_notReading", {31'd0, dRd0}, 32'd0);
    dEn0 = 1'b0;
    tick();
    check("rd_doneDrop", {31'd0, done0}, 32'd0);
    check("rd_fetchResume", {31'd0, iValid0}, 32'd1);

    // Data write
    dAddr = 15'h0004; dData = 16'hBEEF; dWr = 1'b1; dEn0 = 1'b1;
    tick();
    check("wr_strobe", {31'd0, memWr0}, 32'd1);
    check("wr_addr", {16'd0, memAddr0}, 32'h8004);
    check("wr_bus", {16'd0, bus0}, 32'hBEEF);
    tick();
    check("wr_done", {31'd0, done0}, 32'd1);
    check("wr_strobeOff", {31'd0, memWr0}, 32'd0);
    check("wr_busReleased", {16'd0, bus0}, 32'hA5A5);
    check("wr_memData", {16'd0, wrData0}, 32'hBEEF);
    dEn0 = 1'b0; dWr = 1'b0;
    tick();

    // Swap with write also asserted: swap wins
    dAddr = 15'h0050; dData = 16'h00FF; dSwp = 1'b1; dWr = 1'b1; dEn0 = 1'b1;
    tick();
    check("swp_readPhase", {31'd0, dRd0}, 32'd1);
    check("swp_readNoWr", {31'd0, memWr0}, 32'd0);
    check("swp_addr", {16'd0, memAddr0}, 32'h8050);
    tick();
    check("swp_oldData", {16'd0, dOut0}, 32'h1111);
    check("swp_writePhase", {31'd0, memWr0}, 32'd1);
    check("swp_bus", {16'd0, bus0}, 32'h00FF);
    check("swp_noEarlyDone", {31'd0, done0}, 32'd0);
    tick();
    check("swp_done", {31'd0, done0}, 32'd1);
    check("swp_memAddr", {16'd0, wrAddr0}, 32'h8050);
    check("swp_memData", {16'd0, wrData0}, 32'h00FF);
    dEn0 = 1'b0; dSwp = 1'b0; dWr = 1'b0;
    tick();
    check("swp_singleDone", {31'd0, done0}, 32'd0);

`ifdef CORE_MEM_IPAUSE_EN
    // Paused fetch still samples the data request
    iPause = 1'b1; dAddr = 15'h0123; dEn0 = 1'b1;
    tick();
    check("pause_noValid", {31'd0, iValid0}, 32'd0);
    check("pause_busy", {31'd0, busy0}, 32'd1);
    tick();
    check("pause_done", {31'd0, done0}, 32'd1);
    check("pause_rdData", {16'd0, dOut0}, 32'h1234);
    iPause = 1'b0; dEn0 = 1'b0;
    tick();
`endif

    // Three wait states: one fetch every four cycles
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (iValid3) cnt++;
    end
    check("w3_fetchRate", cnt, 32'd2);
    check("w3_fetchData", {16'd0, iData3}, 32'hA5A5);

    // Three wait states: read slot spans four cycles
    dAddr = 15'h0200; dEn3 = 1'b1;
    for (int k = 0; k < 20 && !busy3; k++) tick();
    check("w3_rdStart", {31'd0, busy3}, 32'd1);
    check("w3_rdAddr", {16'd0, memAddr3}, 32'h8200);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w3_rdHold", {30'd0, busy3, done3}, 32'd2);
    end
    tick();
    check("w3_rdDone", {31'd0, done3}, 32'd1);
    check("w3_rdData", {16'd0, dOut3}, 32'hC3C3);
    check("w3_rdIdle", {31'd0, busy3}, 32'd0);
    dEn3 = 1'b0;

    // Reset during the second cycle of a read slot
    tick(); tick();
    dEn3 = 1'b1;
    for (int k = 0; k < 20 && !busy3; k++) tick();
    check("w3_rst_rdStart", {31'd0, busy3}, 32'd1);
    tick();
    rstn3 = 1'b0;
    dEn3 = 1'b0;
    #1;
    check("w3_rst_busy", {31'd0, busy3}, 32'd0);
    check("w3_rst_reading", {31'd0, dRd3}, 32'd0);
    check("w3_rst_dData", {16'd0, dOut3}, 32'd0);
    check("w3_rst_bus", {16'd0, bus3}, 32'hA5A5);
    tick();
    rstn3 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done3) cnt++;
    end
    check("w3_rst_noDone", cnt, 32'd0);
    check("w3_rst_idle", {30'd0, busy3, memWr3}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
